// File: rtl/ram_pkg.sv
// Shared definitions for the sized byte RAM: access opcodes, controller states
// and access-size encoding.
package ram_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } size_t;

    function automatic logic [2:0] size_bytes(input size_t size);
        case (size)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/sized_byte_ram_if.sv
// Request/response bundle between a memory master and sized_byte_ram.
interface sized_byte_ram_if;

    logic        MOV;
    logic        ReadWrite;
    logic [5:0]  OP;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        Err;

    modport master (
        output MOV, ReadWrite, OP, Address, DataIn,
        input  DataOut, MOC, Err
    );

    modport slave (
        input  MOV, ReadWrite, OP, Address, DataIn,
        output DataOut, MOC, Err
    );

endinterface

// File: rtl/ram_lane_fmt.sv
// Combinational access formatter: decodes the opcode, flags faulting accesses,
// maps store data onto big-endian byte lanes and extends loaded data.
module ram_lane_fmt
    import ram_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic [5:0]  op,
    input  logic        read_write,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic [31:0] rd_word,
    output logic        is_load,
    output logic        fault,
    output logic [31:0] load_data,
    output logic [31:0] wr_word,
    output logic [3:0]  wr_mask
);

    size_t       size;
    logic        known;
    logic        is_signed;
    logic        misaligned;
    logic        out_of_range;
    logic [2:0]  nbytes;
    logic [32:0] last_addr;

    always_comb begin
        known     = 1'b1;
        is_load   = 1'b0;
        is_signed = 1'b0;
        size      = WORD;
        case (op)
            OP_LW:  begin is_load = 1'b1; size = WORD; end
            OP_LH:  begin is_load = 1'b1; is_signed = 1'b1; size = HALF; end
            OP_LHU: begin is_load = 1'b1; size = HALF; end
            OP_LB:  begin is_load = 1'b1; is_signed = 1'b1; size = BYTE; end
            OP_LBU: begin is_load = 1'b1; size = BYTE; end
            OP_SW:  size = WORD;
            OP_SH:  size = HALF;
            OP_SB:  size = BYTE;
            default: known = 1'b0;
        endcase
    end

    // The end address is computed one bit wider so accesses near 2^32 cannot wrap into range.
    always_comb begin
        nbytes       = size_bytes(size);
        misaligned   = ((size == WORD) && (address[1:0] != 2'b00)) ||
                       ((size == HALF) && address[0]);
        last_addr    = {1'b0, address} + {30'd0, nbytes} - 33'd1;
        out_of_range = (last_addr >= 33'(DEPTH));
        fault        = !known || (is_load != read_write) || misaligned || out_of_range;
    end

    always_comb begin
        case (size)
            BYTE:    load_data = {{24{is_signed & rd_word[31]}}, rd_word[31:24]};
            HALF:    load_data = {{16{is_signed & rd_word[31]}}, rd_word[31:16]};
            default: load_data = rd_word;
        endcase
    end

    // Lane 0 is the lowest address and sits in bits 31:24, so the MSB lands first.
    always_comb begin
        case (size)
            BYTE: begin
                wr_word = {data_in[7:0], 24'd0};
                wr_mask = 4'b0001;
            end
            HALF: begin
                wr_word = {data_in[15:0], 16'd0};
                wr_mask = 4'b0011;
            end
            default: begin
                wr_word = data_in;
                wr_mask = 4'b1111;
            end
        endcase
        if (fault || is_load) begin
            wr_mask = 4'b0000;
        end
    end

endmodule

// File: rtl/sized_byte_ram.sv
// Byte-addressed big-endian RAM with a MOV/MOC handshake, programmable wait
// states and sized loads/stores with fault reporting.
module sized_byte_ram
    import ram_pkg::*;
#(
    parameter int DEPTH    = 512,
    parameter int WAIT_CYC = 1
) (
    input logic             clk,
    input logic             reset,
    sized_byte_ram_if.slave bus
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_cnt;

    logic        req_rw;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_din;

    logic        sel_rw;
    logic [5:0]  sel_op;
    logic [31:0] sel_addr;
    logic [31:0] sel_din;

    logic [AW-1:0] lane_idx [4];
    logic [31:0]   rd_word;
    logic          is_load;
    logic          fault;
    logic [31:0]   load_data;
    logic [31:0]   wr_word;
    logic [3:0]    wr_mask;
    logic          do_access;

    logic        fault_r;
    logic [31:0] data_out;
    logic        moc;
    logic        err;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.MOV) begin
                    next_state = (WAIT_CYC == 0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (wait_cnt == 4'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!bus.MOV) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
            req_rw   <= 1'b0;
            req_op   <= 6'd0;
            req_addr <= 32'd0;
            req_din  <= 32'd0;
        end else if ((state == IDLE) && bus.MOV) begin
            wait_cnt <= CNT_LOAD;
            req_rw   <= bus.ReadWrite;
            req_op   <= bus.OP;
            req_addr <= bus.Address;
            req_din  <= bus.DataIn;
        end else if ((state == BUSY) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Without wait states the access happens on the capture edge, so the live inputs are used.
    always_comb begin
        sel_rw   = req_rw;
        sel_op   = req_op;
        sel_addr = req_addr;
        sel_din  = req_din;
        if (state == IDLE) begin
            sel_rw   = bus.ReadWrite;
            sel_op   = bus.OP;
            sel_addr = bus.Address;
            sel_din  = bus.DataIn;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_idx[i] = sel_addr[AW-1:0] + AW'(i);
        end
        rd_word = {mem[lane_idx[0]], mem[lane_idx[1]], mem[lane_idx[2]], mem[lane_idx[3]]};
    end

    ram_lane_fmt #(
        .DEPTH (DEPTH)
    ) u_fmt (
        .op         (sel_op),
        .read_write (sel_rw),
        .address    (sel_addr),
        .data_in    (sel_din),
        .rd_word    (rd_word),
        .is_load    (is_load),
        .fault      (fault),
        .load_data  (load_data),
        .wr_word    (wr_word),
        .wr_mask    (wr_mask)
    );

    assign do_access = (next_state == DONE) && (state != DONE);

    always_ff @(posedge clk) begin
        if (do_access) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[lane_idx[i]] <= wr_word[31 - 8*i -: 8];
                end
            end
        end
    end

    // MOC and Err lag DONE by one edge, which keeps MOC up for one cycle after MOV is seen low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_r  <= 1'b0;
            data_out <= 32'd0;
            moc      <= 1'b0;
            err      <= 1'b0;
        end else begin
            moc <= (state == DONE);
            err <= (state == DONE) && fault_r;
            if (do_access) begin
                fault_r <= fault;
                if (fault) begin
                    data_out <= 32'd0;
                end else if (is_load) begin
                    data_out <= load_data;
                end
            end
        end
    end

    assign bus.DataOut = data_out;
    assign bus.MOC     = moc;
    assign bus.Err     = err;

endmodule

// File: tb/tb_sized_byte_ram.sv
// Testbench for sized_byte_ram: three instances (1, 3 and 0 wait states) driven
// with directed and random accesses against a byte-array reference model.
module tb_sized_byte_ram;

    localparam int DEPTH = 512;
    localparam int NDUT  = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic        mov  [NDUT];
    logic        rw   [NDUT];
    logic [5:0]  op   [NDUT];
    logic [31:0] addr [NDUT];
    logic [31:0] din  [NDUT];
    logic [31:0] dout [NDUT];
    logic        moc  [NDUT];
    logic        err  [NDUT];

    int wait_of [NDUT] = '{1, 3, 0};

    logic [7:0]  mdl_mem  [NDUT][DEPTH];
    logic [31:0] mdl_dout [NDUT];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [5:0] op_list [8] = '{6'b100011, 6'b100001, 6'b100101, 6'b100000,
                                6'b100100, 6'b101011, 6'b101001, 6'b101000};

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sized_byte_ram_if bus ();

        assign bus.MOV       = mov[g];
        assign bus.ReadWrite = rw[g];
        assign bus.OP        = op[g];
        assign bus.Address   = addr[g];
        assign bus.DataIn    = din[g];
        assign dout[g]       = bus.DataOut;
        assign moc[g]        = bus.MOC;
        assign err[g]        = bus.Err;

        sized_byte_ram #(
            .DEPTH    (DEPTH),
            .WAIT_CYC ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the access rules: sizes, faults, big-endian bytes, extension.
    task automatic model_access(input int d, input logic r, input logic [5:0] o,
                                input logic [31:0] a, input logic [31:0] di,
                                output logic exp_err);
        int     n;
        bit     ld;
        bit     sgn;
        bit     known;
        longint v;
        known = 1'b1;
        ld    = 1'b0;
        sgn   = 1'b0;
        n     = 4;
        case (o)
            6'b100011: begin n = 4; ld = 1'b1; end
            6'b100001: begin n = 2; ld = 1'b1; sgn = 1'b1; end
            6'b100101: begin n = 2; ld = 1'b1; end
            6'b100000: begin n = 1; ld = 1'b1; sgn = 1'b1; end
            6'b100100: begin n = 1; ld = 1'b1; end
            6'b101011: n = 4;
            6'b101001: n = 2;
            6'b101000: n = 1;
            default:   known = 1'b0;
        endcase
        exp_err = !known || (ld != r) || ((a % n) != 0) ||
                  ((longint'(a) + n - 1) >= DEPTH);
        if (exp_err) begin
            mdl_dout[d] = 32'd0;
        end else if (ld) begin
            v = 0;
            for (int k = 0; k < n; k++) begin
                v = v * 256 + longint'(mdl_mem[d][int'(a) + k]);
            end
            if (sgn && (v >= (64'sd1 << (8*n - 1)))) begin
                v = v - (64'sd1 << (8*n));
            end
            mdl_dout[d] = v[31:0];
        end else begin
            for (int k = 0; k < n; k++) begin
                mdl_mem[d][int'(a) + k] = 8'((di >> (8*(n - 1 - k))) & 32'hFF);
            end
        end
    endtask

    // Full handshake: MOV held until MOC, then for `hold` more cycles, then dropped.
    task automatic applyStimulus(input int d, input logic r, input logic [5:0] o,
                                 input logic [31:0] a, input logic [31:0] di,
                                 input int hold, input string tag);
        logic exp_err;
        int   c;
        @(negedge clk);
        rw[d]   = r;
        op[d]   = o;
        addr[d] = a;
        din[d]  = di;
        mov[d]  = 1'b1;
        model_access(d, r, o, a, di, exp_err);
        @(posedge clk);
        @(negedge clk);
        rw[d]   = 1'($urandom);
        op[d]   = 6'($urandom);
        addr[d] = $urandom;
        din[d]  = $urandom;
        c = 0;
        while (!moc[d] && (c < 20)) begin
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(c), 32'(wait_of[d] + 1));
        check({tag, "_err"}, {31'd0, err[d]}, {31'd0, exp_err});
        check({tag, "_dout"}, dout[d], mdl_dout[d]);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_moc_held"}, {31'd0, moc[d]}, 32'd1);
        end
        mov[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_moc_tail"}, {31'd0, moc[d]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_moc_drop"}, {31'd0, moc[d]}, 32'd0);
        check({tag, "_err_clear"}, {31'd0, err[d]}, 32'd0);
    endtask

    // MOV high for a single sampling edge only.
    task automatic applyPulse(input int d, input logic r, input logic [5:0] o,
                              input logic [31:0] a, input logic [31:0] di, input string tag);
        logic exp_err;
        int   c;
        @(negedge clk);
        rw[d]   = r;
        op[d]   = o;
        addr[d] = a;
        din[d]  = di;
        mov[d]  = 1'b1;
        model_access(d, r, o, a, di, exp_err);
        @(posedge clk);
        @(negedge clk);
        mov[d] = 1'b0;
        c = 0;
        while (!moc[d] && (c < 20)) begin
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(c), 32'(wait_of[d] + 1));
        check({tag, "_err"}, {31'd0, err[d]}, {31'd0, exp_err});
        check({tag, "_dout"}, dout[d], mdl_dout[d]);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_moc_single"}, {31'd0, moc[d]}, 32'd0);
    endtask

    task automatic checkOutput(input int d, input string tag);
        check({tag, "_dout"}, dout[d], 32'd0);
        check({tag, "_moc"}, {31'd0, moc[d]}, 32'd0);
        check({tag, "_err"}, {31'd0, err[d]}, 32'd0);
    endtask

    initial begin
        logic       r;
        logic [5:0] o;
        logic [31:0] a;

        for (int d = 0; d < NDUT; d++) begin
            mov[d]      = 1'b0;
            rw[d]       = 1'b0;
            op[d]       = 6'd0;
            addr[d]     = 32'd0;
            din[d]      = 32'd0;
            mdl_dout[d] = 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mdl_mem[d][i] = 8'd0;
            end
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput(d, $sformatf("reset_d%0d", d));
        end
        reset = 1'b0;

        for (int w = 0; w < DEPTH / 4; w++) begin
            applyStimulus(0, 1'b0, 6'b101011, 32'(4*w), $urandom, 0, "fill");
        end

        applyStimulus(0, 1'b0, 6'b101011, 32'h10, 32'hDEADBEEF, 0, "sw_beef");
        applyStimulus(0, 1'b1, 6'b100011, 32'h10, 32'h0, 0, "lw_beef");
        check("lw_beef_const", dout[0], 32'hDEADBEEF);
        applyStimulus(0, 1'b1, 6'b100000, 32'h10, 32'h0, 0, "lb");
        check("lb_const", dout[0], 32'hFFFFFFDE);
        applyStimulus(0, 1'b1, 6'b100100, 32'h10, 32'h0, 0, "lbu");
        check("lbu_const", dout[0], 32'h000000DE);
        applyStimulus(0, 1'b1, 6'b100001, 32'h12, 32'h0, 0, "lh");
        check("lh_const", dout[0], 32'hFFFFBEEF);
        applyStimulus(0, 1'b1, 6'b100101, 32'h12, 32'h0, 0, "lhu");
        check("lhu_const", dout[0], 32'h0000BEEF);
        applyStimulus(0, 1'b0, 6'b101000, 32'h13, 32'h000000A5, 0, "sb");
        applyStimulus(0, 1'b1, 6'b100011, 32'h10, 32'h0, 0, "lw_after_sb");
        check("lw_after_sb_const", dout[0], 32'hDEADBEA5);

        applyStimulus(0, 1'b1, 6'b100011, 32'h11, 32'h0, 0, "lw_misaligned");
        check("lw_misaligned_const", dout[0], 32'h0);
        applyStimulus(0, 1'b0, 6'b101001, 32'h1FF, 32'h0000CAFE, 0, "sh_oob");
        applyStimulus(0, 1'b1, 6'b100100, 32'h1FF, 32'h0, 0, "lbu_oob_check");
        applyStimulus(0, 1'b1, 6'b101011, 32'h10, 32'h0, 0, "sw_as_read");
        applyStimulus(0, 1'b0, 6'b100011, 32'h10, 32'h0, 0, "lw_as_write");
        applyStimulus(0, 1'b1, 6'b111111, 32'h10, 32'h0, 0, "bad_op");
        applyStimulus(0, 1'b1, 6'b100011, 32'h1FC, 32'h0, 0, "lw_last_word");
        applyStimulus(0, 1'b1, 6'b100011, 32'h200, 32'h0, 0, "lw_past_end");

        applyStimulus(0, 1'b1, 6'b100011, 32'h10, 32'h0, 5, "hold5");
        applyPulse(0, 1'b1, 6'b100001, 32'h10, 32'h0, "pulse_w1");

        applyStimulus(1, 1'b0, 6'b101011, 32'h40, 32'h8091A2B3, 0, "w3_sw");
        applyPulse(1, 1'b1, 6'b100011, 32'h40, 32'h0, "w3_pulse_lw");
        check("w3_pulse_lw_const", dout[1], 32'h8091A2B3);
        applyStimulus(1, 1'b0, 6'b101011, 32'h42, 32'h0, 0, "w3_sw_misaligned");
        applyStimulus(1, 1'b1, 6'b100001, 32'h40, 32'h0, 2, "w3_lh");

        applyStimulus(2, 1'b0, 6'b101001, 32'h80, 32'h00007F01, 0, "w0_sh");
        applyStimulus(2, 1'b1, 6'b100000, 32'h80, 32'h0, 1, "w0_lb");
        applyPulse(2, 1'b1, 6'b100101, 32'h80, 32'h0, "w0_pulse_lhu");
        check("w0_pulse_lhu_const", dout[2], 32'h00007F01);

        // Reset while instance 0 sits in BUSY of a store; that store must never land.
        @(negedge clk);
        rw[0]   = 1'b0;
        op[0]   = 6'b101011;
        addr[0] = 32'h20;
        din[0]  = 32'h12345678;
        mov[0]  = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy_moc", {31'd0, moc[0]}, 32'd0);
        @(negedge clk);
        mov[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            mdl_dout[d] = 32'd0;
            checkOutput(d, $sformatf("rst_mid_d%0d", d));
        end
        applyStimulus(0, 1'b1, 6'b100011, 32'h20, 32'h0, 0, "lw_after_rst");

        for (int t = 0; t < 150; t++) begin
            o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 7)];
            r = o[3] ? 1'b0 : 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                r = ~r;
            end
            a = 32'($urandom_range(0, DEPTH + 7));
            if ($urandom_range(0, 3) != 0) begin
                a = a & ~32'h3;
            end
            applyStimulus(0, r, o, a, $urandom, $urandom_range(0, 2), $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sized_byte_ram.md
SIZED_BYTE_RAM -- requirements
Module: sized_byte_ram

Interface
REQ-001 Parameter DEPTH, default 512: memory size in bytes; power of two, range 64..65536.
REQ-002 Parameter WAIT_CYC, default 1: access wait states; range 0..15.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 MOV  input  1  memory-operation-valid request, level held by the master until MOC.
REQ-007 ReadWrite  input  1  1 = read, 0 = write.
REQ-008 OP  input  6  access type: 100011 lw, 100001 lh, 100101 lhu, 100000 lb, 100100 lbu, 101011 sw, 101001 sh, 101000 sb.
REQ-009 Address  input  32  byte address, big-endian.
REQ-010 DataIn  input  32  store data, right-justified.
REQ-011 DataOut  output  32  load result, registered.
REQ-012 MOC  output  1  memory-operation-complete, registered.
REQ-013 Err  output  1  access-fault flag, valid while MOC=1.

Function
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 Transitions: IDLE->BUSY on a rising edge with MOV=1; BUSY->DONE after WAIT_CYC cycles in BUSY; DONE->IDLE on a rising edge with MOV=0.
REQ-016 With WAIT_CYC=0, IDLE goes directly to DONE.
REQ-017 Request capture: ReadWrite, OP, Address and DataIn are latched on the IDLE->BUSY/DONE edge; input changes after that edge are ignored.
REQ-018 Latency: MOC rises exactly WAIT_CYC+1 cycles after the sampling edge.
REQ-019 MOC stays 1 for the whole of DONE and drops on the edge after MOV is seen 0.
REQ-020 If MOV is already 0 on entry to DONE, MOC is high for exactly one cycle.
REQ-021 MOV deassertion during BUSY does not abort the access.
REQ-022 Memory access timing: the access is performed on the edge that enters DONE.
REQ-023 Write byte order: store writes Mem[A]=MSB ... Mem[A+n-1]=LSB of the low n bytes of DataIn.
REQ-024 Read byte order: a load assembles bytes in the same order as a store.
REQ-025 Load extension: lb/lh sign-extend to 32 bits; lbu/lhu zero-extend.
REQ-026 Fault conditions, Err=1:
- OP not in the REQ-008 list;
- OP direction disagrees with ReadWrite (load OP with ReadWrite=0, store OP with ReadWrite=1);
- word with Address[1:0]!=0, or half with Address[0]!=0;
- Address+size-1 >= DEPTH.
REQ-027 Faulted access behaviour: no memory byte changes, DataOut=0, MOC still asserts with normal latency.
REQ-028 Output hold: DataOut holds its value after a load until the next completed load or fault; stores leave DataOut unchanged.
REQ-029 Err clears on DONE->IDLE.
REQ-030 Back-to-back: a new request is accepted no earlier than the edge after returning to IDLE, giving at least one idle cycle between MOC pulses.

Reset
REQ-031 Reset value of every output: DataOut=0, MOC=0, Err=0.
REQ-032 Reset forces FSM=IDLE and wait counter=0.
REQ-033 Reset mid-BUSY abandons the access: no memory write occurs.
REQ-034 Memory array contents are not reset.

Structure
REQ-035 Shared package ram_pkg holds the OP code constants, the FSM state enum and the size encoding (BYTE/HALF/WORD).
REQ-036 One combinational sub-module ram_lane_fmt performs OP decode, size, fault detection and load extension; sized_byte_ram holds the FSM, counter, registers and byte array.

Verification
REQ-037 Store and load word: sw 0xDEADBEEF @0x10, WAIT_CYC=1 -> MOC 2 cycles after MOV sampled, Err=0; Mem[0x10..0x13]=DE,AD,BE,EF; lw @0x10 -> DataOut=0xDEADBEEF.
REQ-038 Sub-word extension: lb @0x10 -> 0xFFFFFFDE; lbu -> 0x000000DE; lh @0x12 -> 0xFFFFBEEF; lhu -> 0x0000BEEF.
REQ-039 Faults:
- lw @0x11 -> Err=1, DataOut=0;
- sh @0x1FF with DEPTH=512 -> Err=1, memory unchanged;
- OP=101011 with ReadWrite=1 -> Err=1.
REQ-040 Handshake: MOV held 5 cycles after MOC -> MOC held until MOV low, then drops next edge; MOV pulsed one cycle with WAIT_CYC=3 -> single-cycle MOC 4 cycles later.
REQ-041 Reset mid-operation: reset asserted in BUSY of sw 0x12345678 @0x20 -> MOC=0 immediately, Mem[0x20..0x23] unchanged, next request completes normally.
